// File: rtl/multi_clock_enable_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel enable generator.
package clock_enable_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } enb_mode_t;

  function automatic int calc_pre_limit(input int base_us, input int clkfreq_mhz);
    return base_us * clkfreq_mhz;
  endfunction

  // Register/port widths must stay at least 1 bit even for a count of 1.
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_clock_enable_channel.sv
// One enable channel: counts base ticks, periodic or one-shot, 1-cycle pulse on the terminal tick.
// Pulse is combinational from q/period/busy plus base_tick; no backpressure, pulses are never held.
module enb_channel
  import clock_enable_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic             ch_en,
  input  logic             start,
  input  logic             base_tick,
  output logic             enb,
  output logic             busy
);

  logic [CNT_W-1:0] q;
  logic [CNT_W-1:0] period;
  enb_mode_t        mode;
  logic             live;
  logic             at_last;

  // A zero period never reaches its terminal count, so the channel stays silent.
  assign live    = (period != '0);
  assign at_last = live && (q == period - CNT_W'(1));
  assign enb     = base_tick && at_last && ((mode == MODE_ONESHOT) ? busy : ch_en);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q      <= '0;
      busy   <= 1'b0;
      period <= CNT_W'(DEFAULT_PERIOD);
      mode   <= MODE_PERIODIC;
    end else begin
      if (cfg_wr) begin
        period <= cfg_period;
        mode   <= enb_mode_t'(cfg_oneshot);
      end
      if (clr || cfg_wr) begin
        q    <= '0;
        busy <= 1'b0;
      end else if (mode == MODE_ONESHOT) begin
        if (start) begin
          q    <= '0;
          busy <= live;
        end else if (busy && base_tick) begin
          if (at_last) begin
            q    <= '0;
            busy <= 1'b0;
          end else begin
            q <= q + CNT_W'(1);
          end
        end
      end else begin
        busy <= 1'b0;
        if (!ch_en) begin
          q <= '0;
        end else if (base_tick && live) begin
          q <= at_last ? '0 : q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/multi_clock_enable.sv
// Shared prescaler plus NUM_CH programmable enable channels on the common clk.
// base_tick/enb_out are combinational from registered state; free-running, no backpressure.
module multi_clock_enable
  import clock_enable_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CLKFREQ_MHZ    = 100,
  parameter int BASE_US        = 1,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clr,
  input  logic                            cfg_we,
  input  logic [safe_clog2(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]                cfg_period,
  input  logic                            cfg_oneshot,
  input  logic [NUM_CH-1:0]               ch_en,
  input  logic [NUM_CH-1:0]               start,
  output logic                            base_tick,
  output logic [NUM_CH-1:0]               enb_out,
  output logic [NUM_CH-1:0]               busy
);

  localparam int CH_W      = safe_clog2(NUM_CH);
  localparam int PRE_LIMIT = calc_pre_limit(BASE_US, CLKFREQ_MHZ);
  localparam int PRE_W     = safe_clog2(PRE_LIMIT);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_LIMIT - 1);

  logic [PRE_W-1:0] pre;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
    end else if (clr || (pre == PRE_LAST)) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // reset_n gating keeps base_tick low in reset even when PRE_LIMIT is 1.
  assign base_tick = reset_n && !clr && (pre == PRE_LAST);

  // Indices with no matching channel decode to no write.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    enb_channel #(
      .CNT_W         (CNT_W),
      .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr        (clr),
      .cfg_wr     (cfg_we && (cfg_ch == CH_W'(i))),
      .cfg_period (cfg_period),
      .cfg_oneshot(cfg_oneshot),
      .ch_en      (ch_en[i]),
      .start      (start[i]),
      .base_tick  (base_tick),
      .enb        (enb_out[i]),
      .busy       (busy[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_enable.sv
// Bench for multi_clock_enable: tick-count model checked every cycle plus directed literal checks.
module tb_multi_clock_enable;

  localparam int NCH  = 4;
  localparam int PL   = 4;
  localparam int DEFP = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_period = '0;
  logic        cfg_oneshot = 1'b0;
  logic [3:0]  ch_en = '0;
  logic [3:0]  start = '0;
  logic        base_tick;
  logic [3:0]  enb_out;
  logic [3:0]  busy;
  logic        base_tick3;
  logic [2:0]  enb_out3;
  logic [2:0]  busy3;

  int n_vec = 0;
  int n_err = 0;
  int cyc_no = 0;
  int tick_cnt, first_tick, misaligned = 0;
  int pulse_cnt[NCH], first_pulse[NCH], prev_pulse[NCH], last_pulse[NCH];
  int rel, rs, clr_cyc;

  multi_clock_enable #(.NUM_CH(4), .CLKFREQ_MHZ(4), .BASE_US(1), .CNT_W(16), .DEFAULT_PERIOD(DEFP)) u_dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .ch_en(ch_en), .start(start),
    .base_tick(base_tick), .enb_out(enb_out), .busy(busy)
  );

  // Three-channel copy: index 3 is out of range for it, so its channels must track channels 0..2.
  multi_clock_enable #(.NUM_CH(3), .CLKFREQ_MHZ(4), .BASE_US(1), .CNT_W(16), .DEFAULT_PERIOD(DEFP)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .ch_en(ch_en[2:0]), .start(start[2:0]),
    .base_tick(base_tick3), .enb_out(enb_out3), .busy(busy3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_no++;

  // Model state: cycles since restart, and per channel the number of base ticks counted since arming.
  int m_cyc = 0;
  int m_per[NCH] = '{DEFP, DEFP, DEFP, DEFP};
  bit m_os[NCH]  = '{0, 0, 0, 0};
  int m_n[NCH]   = '{0, 0, 0, 0};
  bit m_arm[NCH] = '{0, 0, 0, 0};

  function automatic bit m_tick();
    return reset_n && !clr && ((m_cyc % PL) == PL - 1);
  endfunction

  function automatic bit m_enb(input int i);
    if (!m_tick() || m_per[i] == 0) return 1'b0;
    if (m_os[i]) return m_arm[i] && (m_n[i] + 1 == m_per[i]);
    return ch_en[i] && (((m_n[i] + 1) % m_per[i]) == 0);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit t;
    bit wr;
    if (!reset_n) begin
      m_cyc = 0;
      for (int i = 0; i < NCH; i++) begin
        m_per[i] = DEFP; m_os[i] = 1'b0; m_n[i] = 0; m_arm[i] = 1'b0;
      end
    end else begin
      t = m_tick();
      m_cyc = clr ? 0 : m_cyc + 1;
      for (int i = 0; i < NCH; i++) begin
        wr = cfg_we && (int'(cfg_ch) == i);
        if (wr) begin
          m_per[i] = int'(cfg_period);
          m_os[i]  = cfg_oneshot;
        end
        if (clr || wr) begin
          m_n[i] = 0; m_arm[i] = 1'b0;
        end else if (m_os[i]) begin
          if (start[i]) begin
            m_n[i] = 0; m_arm[i] = (m_per[i] != 0);
          end else if (m_arm[i] && t) begin
            m_n[i]++;
            if (m_n[i] == m_per[i]) m_arm[i] = 1'b0;
          end
        end else begin
          m_arm[i] = 1'b0;
          if (!ch_en[i]) m_n[i] = 0;
          else if (t && m_per[i] != 0) m_n[i]++;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc_no);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] e_enb;
    logic [3:0] e_busy;
    for (int i = 0; i < NCH; i++) begin
      e_enb[i]  = m_enb(i);
      e_busy[i] = reset_n && m_arm[i];
    end
    cmp("base_tick", {31'b0, base_tick}, {31'b0, m_tick()});
    cmp("enb_out", {28'b0, enb_out}, {28'b0, e_enb});
    cmp("busy", {28'b0, busy}, {28'b0, e_busy});
    cmp("dut3_base_tick", {31'b0, base_tick3}, {31'b0, m_tick()});
    cmp("dut3_enb_out", {29'b0, enb_out3}, {29'b0, e_enb[2:0]});
    cmp("dut3_busy", {29'b0, busy3}, {29'b0, e_busy[2:0]});
  end

  always @(negedge clk) begin
    if (base_tick === 1'b1) begin
      if (first_tick < 0) first_tick = cyc_no;
      tick_cnt++;
    end
    for (int i = 0; i < NCH; i++) begin
      if (enb_out[i] === 1'b1) begin
        pulse_cnt[i]++;
        if (first_pulse[i] < 0) first_pulse[i] = cyc_no;
        prev_pulse[i] = last_pulse[i];
        last_pulse[i] = cyc_no;
        if (base_tick !== 1'b1) misaligned++;
      end
    end
  end

  task automatic clr_log();
    tick_cnt = 0;
    first_tick = -1;
    for (int i = 0; i < NCH; i++) begin
      pulse_cnt[i] = 0; first_pulse[i] = -1; prev_pulse[i] = -1; last_pulse[i] = -1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input int per, input logic os);
    cfg_ch = ch; cfg_period = 16'(per); cfg_oneshot = os; cfg_we = 1'b1;
    run(1);
    cfg_we = 1'b0;
  endtask

  // Parks in the cycle whose base_tick is the (want+1)-th since the last clr_log.
  task automatic wait_tick(input int want);
    int k;
    k = 0;
    while (!(base_tick === 1'b1 && tick_cnt == want) && k < 64) begin
      run(1);
      k++;
    end
    cmp("wait_tick_bound", {31'b0, k < 64}, 32'd1);
  endtask

  initial begin
    clr_log();
    ch_en = 4'b0001;
    run(3);
    cmp("reset_base_tick", {31'b0, base_tick}, 32'd0);
    cmp("reset_enb_out", {28'b0, enb_out}, 32'd0);
    cmp("reset_busy", {28'b0, busy}, 32'd0);

    // Periodic ch0, period 3 base ticks of 4 clocks each.
    reset_n = 1'b1; rel = cyc_no; clr_log();
    run(30);
    cmp("p1_first_tick", first_tick - rel, 32'd3);
    cmp("p1_first_pulse", first_pulse[0] - rel, 32'd11);
    cmp("p1_gap", last_pulse[0] - prev_pulse[0], 32'd12);
    cmp("p1_count", pulse_cnt[0], 32'd2);

    // Period 1 then period 0 on ch1.
    ch_en[1] = 1'b1;
    cfg(2'd1, 1, 1'b0); clr_log(); run(40);
    cmp("p2_per1_count", pulse_cnt[1], 32'd10);
    cmp("p2_per1_gap", last_pulse[1] - prev_pulse[1], 32'd4);
    cfg(2'd1, 0, 1'b0); clr_log(); run(100);
    cmp("p2_per0_count", pulse_cnt[1], 32'd0);

    // One-shot ch2, period 5, then a restart on the 3rd tick.
    cfg(2'd2, 5, 1'b1);
    start[2] = 1'b1; run(1); start[2] = 1'b0;
    cmp("p3_busy_next", {31'b0, busy[2]}, 32'd1);
    clr_log(); run(25);
    cmp("p3_pulse_count", pulse_cnt[2], 32'd1);
    cmp("p3_on_5th_tick", first_pulse[2] - first_tick, 32'd16);
    cmp("p3_busy_after", {31'b0, busy[2]}, 32'd0);
    start[2] = 1'b1; run(1); start[2] = 1'b0; clr_log();
    wait_tick(2);
    start[2] = 1'b1; rs = cyc_no; run(1); start[2] = 1'b0;
    run(30);
    cmp("p3_restart_count", pulse_cnt[2], 32'd1);
    cmp("p3_restart_pos", first_pulse[2] - rs, 32'd20);

    // clr on a tick cycle.
    wait_tick(tick_cnt);
    clr = 1'b1; #1;
    cmp("p4_clr_base_tick", {31'b0, base_tick}, 32'd0);
    cmp("p4_clr_enb_out", {28'b0, enb_out}, 32'd0);
    clr_cyc = cyc_no; run(1); clr = 1'b0; clr_log(); run(20);
    cmp("p4_tick_after_clr", first_tick - clr_cyc, 32'd4);
    cmp("p4_ch0_third_tick", first_pulse[0] - clr_cyc, 32'd12);

    // Async reset between edges while ch2 is armed and base_tick is high.
    start[2] = 1'b1; run(1); start[2] = 1'b0; run(2);
    wait_tick(tick_cnt);
    cmp("p5_busy_before", {31'b0, busy[2]}, 32'd1);
    #2 reset_n = 1'b0; #1;
    cmp("p5_rst_base_tick", {31'b0, base_tick}, 32'd0);
    cmp("p5_rst_enb_out", {28'b0, enb_out}, 32'd0);
    cmp("p5_rst_busy", {28'b0, busy}, 32'd0);
    run(2);
    reset_n = 1'b1; rel = cyc_no; ch_en = 4'b0111; clr_log(); run(30);
    cmp("p5_ch0_first", first_pulse[0] - rel, 32'd11);
    cmp("p5_ch1_first", first_pulse[1] - rel, 32'd11);
    cmp("p5_ch2_periodic", first_pulse[2] - rel, 32'd11);
    cmp("p5_busy_idle", {28'b0, busy}, 32'd0);

    // Config write and start on the same channel in the same cycle.
    cfg_ch = 2'd2; cfg_period = 16'd2; cfg_oneshot = 1'b1; cfg_we = 1'b1; start[2] = 1'b1;
    run(1);
    cfg_we = 1'b0; start[2] = 1'b0;
    cmp("p6_no_busy", {31'b0, busy[2]}, 32'd0);
    clr_log(); run(20);
    cmp("p6_no_pulse", pulse_cnt[2], 32'd0);

    // Index 3 is live on the 4-channel DUT and out of range on the 3-channel copy.
    ch_en[3] = 1'b1;
    cfg(2'd3, 1, 1'b0); clr_log(); run(40);
    cmp("p6_ch3_count", pulse_cnt[3], 32'd10);
    cmp("misaligned_pulses", misaligned, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
